// File: rtl/bus_pkg.sv
// Definitions shared by the bus arbiter and the tristate drivers that sit on its bus.
package bus_pkg;

    localparam int BUS_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: searches from last+1 upward, wrapping, and returns
// the first requester found.
module rr_pick
    import bus_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] last,
    output logic                     any,
    output logic [$clog2(N_REQ)-1:0] winner
);

    localparam int IDW = $clog2(N_REQ);

    logic [IDW-1:0] cand;

    always_comb begin
        any    = 1'b0;
        winner = '0;
        cand   = '0;
        // The offset runs 1..N_REQ, so the previous winner is checked last.
        for (int i = 1; i <= N_REQ; i++) begin
            cand = IDW'((int'(last) + i) % N_REQ);
            if (!any && req[cand]) begin
                any    = 1'b1;
                winner = cand;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin owner sequencing for a shared tristate bus. Only one oe bit is high at a time,
// tenures are capped at MAX_HOLD cycles, and every hand-over has a GAP_CYCLES dead time.
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int GAP_CYCLES = 1,
    parameter int MAX_HOLD   = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req,
    output logic [N_REQ-1:0]         oe,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic                     busy,
    output logic                     preempt
);

    localparam int IDW = $clog2(N_REQ);
    localparam int HW  = $clog2(MAX_HOLD + 1);

    arb_state_t     state_q, state_d;
    logic [N_REQ-1:0] oe_q, oe_d;
    logic [IDW-1:0] grant_q, grant_d;
    logic [IDW-1:0] last_q, last_d;
    logic [HW-1:0]  hold_q, hold_d;
    logic [2:0]     gap_q, gap_d;
    logic           busy_q, busy_d;
    logic           preempt_q, preempt_d;

    logic           pick_any;
    logic [IDW-1:0] pick_winner;

    rr_pick #(
        .N_REQ (N_REQ)
    ) u_rr_pick (
        .req    (req),
        .last   (last_q),
        .any    (pick_any),
        .winner (pick_winner)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            oe_q      <= '0;
            grant_q   <= '0;
            last_q    <= IDW'(N_REQ - 1);
            hold_q    <= '0;
            gap_q     <= '0;
            busy_q    <= 1'b0;
            preempt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            oe_q      <= oe_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            hold_q    <= hold_d;
            gap_q     <= gap_d;
            busy_q    <= busy_d;
            preempt_q <= preempt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        oe_d      = oe_q;
        grant_d   = grant_q;
        last_d    = last_q;
        hold_d    = hold_q;
        gap_d     = gap_q;
        preempt_d = 1'b0;

        case (state_q)
            IDLE: begin
                oe_d = '0;
                if (pick_any) begin
                    state_d = GRANT;
                    oe_d    = N_REQ'(1) << pick_winner;
                    grant_d = pick_winner;
                    last_d  = pick_winner;
                    hold_d  = HW'(1);
                end
            end

            GRANT: begin
                // A release takes priority over a simultaneous hold limit, so no preempt pulse.
                if (!req[grant_q]) begin
                    state_d = GAP;
                    oe_d    = '0;
                    gap_d   = 3'd1;
                end else if (hold_q == HW'(MAX_HOLD)) begin
                    state_d   = GAP;
                    oe_d      = '0;
                    gap_d     = 3'd1;
                    preempt_d = 1'b1;
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end

            GAP: begin
                oe_d = '0;
                if (gap_q < 3'(GAP_CYCLES)) begin
                    gap_d = gap_q + 3'd1;
                end else if (pick_any) begin
                    state_d = GRANT;
                    oe_d    = N_REQ'(1) << pick_winner;
                    grant_d = pick_winner;
                    last_d  = pick_winner;
                    hold_d  = HW'(1);
                end else begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
                oe_d    = '0;
            end
        endcase

        busy_d = (oe_d != '0);
    end

    assign oe       = oe_q;
    assign grant_id = grant_q;
    assign busy     = busy_q;
    assign preempt  = preempt_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: two instances (gap 1 and gap 3, hold limit 4) share one stimulus and
// are compared every cycle against a tenure/idle-run model, with literal checks on instance A.
module tb_bus_arbiter;

    localparam int N      = 4;
    localparam int MAXH   = 4;
    localparam int GAP_A  = 1;
    localparam int GAP_B  = 3;
    localparam int STARVE = (N - 1) * (MAXH + GAP_B) + GAP_B;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req;

    logic [3:0] oe_a, oe_b;
    logic [1:0] gid_a, gid_b;
    logic       busy_a, busy_b, pre_a, pre_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bus_arbiter #(.N_REQ(N), .GAP_CYCLES(GAP_A), .MAX_HOLD(MAXH)) dut_a (
        .clk(clk), .reset(reset), .req(req), .oe(oe_a),
        .grant_id(gid_a), .busy(busy_a), .preempt(pre_a)
    );

    bus_arbiter #(.N_REQ(N), .GAP_CYCLES(GAP_B), .MAX_HOLD(MAXH)) dut_b (
        .clk(clk), .reset(reset), .req(req), .oe(oe_b),
        .grant_id(gid_b), .busy(busy_b), .preempt(pre_b)
    );

    // Model: owner (-1 = none), tenure length so far, length of the current all-zero run.
    typedef struct {
        int owner;
        int len;
        int zeros;
        int last;
        int gid;
        bit pre;
    } mdl_t;

    mdl_t ma, mb;
    bit   armed = 1'b0;

    function automatic mdl_t mstep(input mdl_t s, input logic [3:0] r, input logic rst, input int gap);
        mdl_t n;
        bit   found;
        int   c;
        n     = s;
        n.pre = 1'b0;
        found = 1'b0;
        if (rst) begin
            n.owner = -1;
            n.len   = 0;
            n.zeros = gap;
            n.last  = N - 1;
            n.gid   = 0;
        end else if (n.owner < 0) begin
            if (n.zeros < 1000) n.zeros++;
            if (n.zeros >= gap) begin
                for (int k = 1; k <= N; k++) begin
                    c = (n.last + k) % N;
                    if (!found && r[c]) begin
                        found   = 1'b1;
                        n.owner = c;
                        n.last  = c;
                        n.gid   = c;
                        n.len   = 1;
                    end
                end
            end
        end else if (!r[n.owner]) begin
            n.owner = -1;
            n.zeros = 0;
        end else if (n.len == MAXH) begin
            n.pre   = 1'b1;
            n.owner = -1;
            n.zeros = 0;
        end else begin
            n.len++;
        end
        return n;
    endfunction

    function automatic logic [3:0] moe(input mdl_t s);
        logic [3:0] v;
        v = '0;
        if (s.owner >= 0) v[s.owner] = 1'b1;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            ma    = mstep(ma, req, reset, GAP_A);
            mb    = mstep(mb, req, reset, GAP_B);
            armed = 1'b1;
        end
    end

    int  wait_b [N];
    int  run_b  = 0;
    int  zrun_b = 0;
    bit  seen_b = 1'b0;
    logic [3:0] prev_b = '0;

    initial begin
        forever begin
            @(negedge clk);
            if (armed) begin
                chk("oe_a", 32'(oe_a), 32'(moe(ma)));
                chk("busy_a", 32'(busy_a), 32'(ma.owner >= 0));
                chk("pre_a", 32'(pre_a), 32'(ma.pre));
                if (ma.owner >= 0) chk("gid_a", 32'(gid_a), ma.gid);
                chk("oe_b", 32'(oe_b), 32'(moe(mb)));
                chk("busy_b", 32'(busy_b), 32'(mb.owner >= 0));
                chk("pre_b", 32'(pre_b), 32'(mb.pre));
                if (mb.owner >= 0) chk("gid_b", 32'(gid_b), mb.gid);

                chk("onehot_b", 32'($onehot0(oe_b)), 32'd1);
                if (oe_b != '0) begin
                    if (prev_b == '0) begin
                        if (seen_b) chk("gap_b", 32'(zrun_b >= GAP_B), 32'd1);
                        run_b  = 1;
                        seen_b = 1'b1;
                    end else begin
                        run_b++;
                    end
                    chk("tenure_b", 32'(run_b <= MAXH), 32'd1);
                    zrun_b = 0;
                end else begin
                    zrun_b++;
                end
                if (reset) seen_b = 1'b0;
                prev_b = oe_b;

                for (int i = 0; i < N; i++) begin
                    if (reset) wait_b[i] = 0;
                    else if (req[i] && !oe_b[i]) wait_b[i]++;
                    else wait_b[i] = 0;
                    chk("starve_b", 32'(wait_b[i] <= STARVE), 32'd1);
                end
            end
        end
    end

    // Drive inputs, let one edge pass, then check instance A against literal values.
    task automatic apply(input logic r, input logic [3:0] q, input logic [3:0] e_oe,
                         input logic e_pre, input string nm);
        int idx;
        reset = r;
        req   = q;
        @(posedge clk);
        #2;
        chk({nm, "_oe"}, 32'(oe_a), 32'(e_oe));
        chk({nm, "_pre"}, 32'(pre_a), 32'(e_pre));
        chk({nm, "_busy"}, 32'(busy_a), 32'(e_oe != '0));
        if (e_oe != '0) begin
            idx = 0;
            for (int i = 0; i < N; i++) if (e_oe[i]) idx = i;
            chk({nm, "_gid"}, 32'(gid_a), idx);
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) wait_b[i] = 0;

        apply(1'b1, 4'hF, 4'h0, 1'b0, "rst");
        apply(1'b1, 4'hF, 4'h0, 1'b0, "rst");
        apply(1'b0, 4'hF, 4'h1, 1'b0, "first");

        apply(1'b0, 4'hA, 4'h0, 1'b0, "alt");
        repeat (4) apply(1'b0, 4'hA, 4'h2, 1'b0, "alt1");
        apply(1'b0, 4'hA, 4'h0, 1'b1, "altp");
        repeat (4) apply(1'b0, 4'hA, 4'h8, 1'b0, "alt3");
        apply(1'b0, 4'hA, 4'h0, 1'b1, "altp");
        apply(1'b0, 4'hA, 4'h2, 1'b0, "alt1");

        apply(1'b0, 4'h4, 4'h0, 1'b0, "solo");
        repeat (4) apply(1'b0, 4'h4, 4'h4, 1'b0, "solo");
        apply(1'b0, 4'h4, 4'h0, 1'b1, "solop");
        apply(1'b0, 4'h4, 4'h4, 1'b0, "solo");

        apply(1'b0, 4'h0, 4'h0, 1'b0, "drain");
        apply(1'b0, 4'h0, 4'h0, 1'b0, "drain");
        apply(1'b0, 4'h1, 4'h1, 1'b0, "pulse");
        apply(1'b0, 4'h1, 4'h1, 1'b0, "pulse");
        repeat (3) apply(1'b0, 4'h0, 4'h0, 1'b0, "idle");

        apply(1'b0, 4'h8, 4'h8, 1'b0, "own3");
        apply(1'b0, 4'h8, 4'h8, 1'b0, "own3");
        apply(1'b1, 4'h8, 4'h0, 1'b0, "midrst");
        apply(1'b0, 4'h8, 4'h8, 1'b0, "regrant");

        reset = 1'b0;
        repeat (10000) begin
            @(posedge clk);
            #2;
            for (int b = 0; b < N; b++)
                if ($urandom_range(0, 7) == 0) req[b] = ~req[b];
        end

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Shares one 8-bit tristate data bus between N_REQ bus drivers, such as counters and registers, by sequencing their oe inputs.
- Grants exactly one owner at a time using round-robin priority.
- Enforces a turnaround gap with no driver enabled between owners, so no two tristate drivers ever overlap.
- Limits each tenure to MAX_HOLD cycles so one requester cannot monopolise the bus.

Parameters:
- N_REQ, 4, number of requesters/drivers (2..8).
- GAP_CYCLES, 1, idle cycles with all oe low between two tenures (1..7; 0 not supported).
- MAX_HOLD, 8, maximum consecutive cycles one owner keeps oe (1..255).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- req  in  N_REQ  level request per driver; held high while the driver wants the bus.
- oe  out  N_REQ  output-enable per driver; one-hot or all-zero; registered.
- grant_id  out  $clog2(N_REQ)  index of the current owner; valid only when busy=1; registered.
- busy  out  1  high while any oe bit is high.
- preempt  out  1  one-cycle pulse on the cycle after a tenure is cut by MAX_HOLD while req[owner] is still high.

Behaviour:
- Reset (sampled at posedge clk while reset=1):
  - oe=0, grant_id=0, busy=0, preempt=0, state=IDLE, hold_cnt=0, gap_cnt=0, last=N_REQ-1.
  - last=N_REQ-1 gives req[0] first priority.
  - Reset asserted mid-tenure drops oe to 0 on the next edge; no gap is enforced after reset.
- States: IDLE, GRANT, GAP.
- Round-robin pick:
  - Search starts at (last+1) mod N_REQ and wraps; the first set req bit wins.
  - last updates to the winner on each grant.
- IDLE:
  - oe=0.
  - If req!=0 at an edge, that same edge sets oe[winner]=1, grant_id=winner, busy=1, hold_cnt=1, and moves to GRANT.
  - Latency: req rises before edge k -> oe high after edge k.
- GRANT (evaluated at each edge):
  - If req[owner]=0: oe<=0, enter GAP, gap_cnt<=1.
  - Else if hold_cnt==MAX_HOLD: oe<=0, preempt<=1 for one cycle, enter GAP.
  - Else hold_cnt<=hold_cnt+1.
  - The owner therefore sees oe high for at most MAX_HOLD cycles.
  - Requests from other drivers do not shorten a tenure.
- GAP:
  - oe=0 and busy=0.
  - While gap_cnt<GAP_CYCLES: gap_cnt+1.
  - At the edge where gap_cnt==GAP_CYCLES, arbitrate exactly as in IDLE. Grant directly if req!=0, otherwise go to IDLE.
  - A preempted owner still requesting is eligible again but has lowest priority; it wins again only if no one else requests.
- Outputs change only on clock edges; there is no combinational path from req to oe.
- Invariants:
  - popcount(oe)<=1 always.
  - Between any two distinct high oe pulses there are at least GAP_CYCLES cycles with oe=0, including re-grant to the same owner.
- Simultaneous events:
  - Owner drops req on the same edge hold_cnt hits MAX_HOLD: treat as release, preempt=0.
  - All req drop in GAP: go to IDLE.
  - req bits beyond N_REQ do not exist.
- Widths:
  - hold_cnt is $clog2(MAX_HOLD+1) bits.
  - gap_cnt is 3 bits.
  - Counters saturate and never wrap.

Decomposition:
- Shared package (bus_pkg):
  - State enum arb_state_t {IDLE, GRANT, GAP}.
  - BUS_W=8 constant, shared with bus drivers.
- One sub-module, rr_pick: combinational round-robin picker.
  - Inputs: req, last.
  - Outputs: any, winner.
  - Instantiated once and used from both IDLE and GAP.
- Counters and FSM stay in bus_arbiter.

Test Plan:
Defaults unless stated: N_REQ=4, GAP_CYCLES=1, MAX_HOLD=4.
1. reset held 2 cycles with req=4'b1111 -> oe=0, busy=0. After release, first edge gives oe=4'b0001, grant_id=0.
2. req=4'b1010 held constant -> tenures alternate between owners 1 and 3:
   - oe=4'b0010 for 4 cycles, preempt pulse, 1 zero cycle.
   - Then oe=4'b1000 for 4 cycles, and so on.
3. Only req[2] high continuously -> oe[2] high 4 cycles, 1 low cycle with preempt=1, then high again. Repeats indefinitely.
4. req[0] pulses high for 2 cycles -> oe[0] high for 2 cycles after a 1-cycle latency, then GAP, then IDLE with oe=0.
5. reset asserted during GRANT of owner 3 -> oe=0 next edge. With req=4'b1000 afterwards, re-grant to 3 follows on the first post-reset edge.
6. GAP_CYCLES=3, random req for 10k cycles -> assertions hold throughout:
   - onehot0(oe).
   - At least 3 zero cycles between tenures.
   - Tenure length at most 4.
   - Every continuously asserted req is granted within (N_REQ-1)*(MAX_HOLD+GAP_CYCLES)+GAP_CYCLES cycles.
